// File: rtl/soc_top.sv
// Demo SoC top: after reset, streams a fixed boot message on a UART write-strobe
// interface, then lights the LED once the whole message has gone out.
module soc_top #(
  parameter int START_DELAY = 4,
  parameter int GAP_CYCLES  = 3,
  parameter int REPEAT      = 0
) (
  input  logic       CLK,
  input  logic       RST_N,
  output logic       uart_wr_valid,
  output logic [7:0] uart_wr_data,
  output logic       LED
);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [7:0] START_LAST = 8'(START_DELAY);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam logic [3:0] LAST_IDX   = 4'd13;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       led_q, led_d;

  function automatic logic [7:0] rom_byte(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h48;
      4'd1:    return 8'h65;
      4'd2:    return 8'h6C;
      4'd3:    return 8'h6C;
      4'd4:    return 8'h6F;
      4'd5:    return 8'h2C;
      4'd6:    return 8'h20;
      4'd7:    return 8'h77;
      4'd8:    return 8'h6F;
      4'd9:    return 8'h72;
      4'd10:   return 8'h6C;
      4'd11:   return 8'h64;
      4'd12:   return 8'h21;
      4'd13:   return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

  // The strobe and its byte are loaded on the same edge that enters SEND,
  // so the SEND state and the registered valid always coincide.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    data_d  = 8'h00;
    led_d   = led_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == START_LAST) begin
          state_d = ST_SEND;
          cnt_d   = 8'd0;
          valid_d = 1'b1;
          data_d  = rom_byte(idx_q);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SEND: begin
        if (idx_q == LAST_IDX && REPEAT == 0) begin
          state_d = ST_DONE;
          led_d   = 1'b1;
        end else begin
          if (idx_q == LAST_IDX) begin
            idx_d = 4'd0;
            led_d = ~led_q;
          end else begin
            idx_d = idx_q + 4'd1;
          end
          cnt_d = 8'd0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_SEND;
            valid_d = 1'b1;
            data_d  = rom_byte(idx_d);
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_SEND;
          cnt_d   = 8'd0;
          valid_d = 1'b1;
          data_d  = rom_byte(idx_q);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        led_d = 1'b1;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_WAIT;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      led_q   <= led_d;
    end
  end

  assign uart_wr_valid = valid_q;
  assign uart_wr_data  = data_q;
  assign LED           = led_q;

endmodule

// File: tb/tb_soc_top.sv
// Bench for soc_top: three configurations (defaults, no delay/gap, repeating)
// share clock and reset; a scoreboard queue holds each expected strobe.
module tb_soc_top;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic clk_en = 1'b0;

  logic       v0, v1, v2;
  logic [7:0] d0, d1, d2;
  logic       l0, l1, l2;

  logic       obs_valid [3];
  logic [7:0] obs_data  [3];
  logic       obs_led   [3];

  typedef struct {
    int         inst;
    int         edge_n;
    logic [7:0] data;
  } exp_t;

  exp_t  sb[$];
  int    strobes [3];
  int    checks = 0;
  int    errors = 0;
  string msg = "Hello, world!\n";

  soc_top dut_def (
    .CLK(CLK), .RST_N(RST_N), .uart_wr_valid(v0), .uart_wr_data(d0), .LED(l0)
  );

  soc_top #(.START_DELAY(0), .GAP_CYCLES(0), .REPEAT(0)) dut_fast (
    .CLK(CLK), .RST_N(RST_N), .uart_wr_valid(v1), .uart_wr_data(d1), .LED(l1)
  );

  soc_top #(.START_DELAY(4), .GAP_CYCLES(3), .REPEAT(1)) dut_rep (
    .CLK(CLK), .RST_N(RST_N), .uart_wr_valid(v2), .uart_wr_data(d2), .LED(l2)
  );

  assign obs_valid[0] = v0;
  assign obs_valid[1] = v1;
  assign obs_valid[2] = v2;
  assign obs_data[0]  = d0;
  assign obs_data[1]  = d1;
  assign obs_data[2]  = d2;
  assign obs_led[0]   = l0;
  assign obs_led[1]   = l1;
  assign obs_led[2]   = l2;

  always #5 if (clk_en) CLK = ~CLK;

  task automatic check(input string tag, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, got, exp);
    end
  endtask

  // LED after edge c: defaults finish after edge 58, fast after 15,
  // repeating toggles after 58 and every 56 edges after that.
  function automatic logic led_model(input int inst, input int c);
    case (inst)
      0:       return c >= 58;
      1:       return c >= 15;
      default: return (c < 58) ? 1'b0 : (((c - 58) / 56) % 2 == 0);
    endcase
  endfunction

  task automatic apply_stimulus();
    exp_t e;
    sb.delete();
    for (int i = 0; i < 3; i++) strobes[i] = 0;
    for (int k = 0; k < 14; k++) begin
      e.inst = 0; e.edge_n = 5 + 4 * k; e.data = msg[k]; sb.push_back(e);
      e.inst = 1; e.edge_n = 1 + k;     e.data = msg[k]; sb.push_back(e);
    end
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 14; k++) begin
        e.inst = 2; e.edge_n = 5 + 4 * k + 56 * p; e.data = msg[k]; sb.push_back(e);
      end
  endtask

  task automatic check_output(input int c);
    for (int i = 0; i < 3; i++) begin
      int pos;
      pos = -1;
      for (int j = 0; j < sb.size(); j++)
        if (sb[j].inst == i) begin
          pos = j;
          break;
        end
      if (obs_valid[i] === 1'b1) begin
        strobes[i]++;
        check("strobe_expected", i, {31'd0, pos >= 0}, 32'd1);
        if (pos >= 0) begin
          check("strobe_edge", i, c, sb[pos].edge_n);
          check("strobe_data", i, {24'd0, obs_data[i]}, {24'd0, sb[pos].data});
          sb.delete(pos);
        end
      end else begin
        check("idle_data", i, {24'd0, obs_data[i]}, 32'd0);
        if (pos >= 0 && sb[pos].edge_n <= c) begin
          check("missed_strobe", i, {31'd0, obs_valid[i]}, 32'd1);
          sb.delete(pos);
        end
      end
      check("led", i, {31'd0, obs_led[i]}, {31'd0, led_model(i, c)});
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_valid"}, i, {31'd0, obs_valid[i]}, 32'd0);
      check({tag, "_data"}, i, {24'd0, obs_data[i]}, 32'd0);
      check({tag, "_led"}, i, {31'd0, obs_led[i]}, 32'd0);
    end
  endtask

  task automatic step_edge(input int c);
    @(posedge CLK);
    #1;
    check_output(c);
  endtask

  initial begin
    int remaining;

    // Reset with the clock stopped must clear outputs on its own.
    #3 RST_N = 1'b0;
    #1 check_all_zero("reset_no_clock");

    clk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1 check_all_zero("in_reset");
    end
    @(negedge CLK);
    RST_N = 1'b1;
    apply_stimulus();

    for (int c = 1; c <= 120; c++) step_edge(c);
    check("full_count", 0, strobes[0], 14);
    check("full_count", 1, strobes[1], 14);
    check("repeat_count", 2, strobes[2], 29);

    // Reset while the default instance sits in DONE clears the LED at once.
    #2 RST_N = 1'b0;
    #1 check_all_zero("reset_in_done");
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    apply_stimulus();

    for (int c = 1; c <= 40; c++) begin
      step_edge(c);
      if (strobes[0] == 3) break;
    end
    check("three_strobes_seen", 0, strobes[0], 3);

    // Mid-message reset lands while the third strobe is still high.
    #2 RST_N = 1'b0;
    #1 check_all_zero("reset_mid_msg");
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    apply_stimulus();

    for (int c = 1; c <= 70; c++) step_edge(c);
    check("restart_count", 0, strobes[0], 14);
    check("restart_count", 1, strobes[1], 14);
    remaining = 0;
    foreach (sb[j]) if (sb[j].inst != 2) remaining++;
    check("scoreboard_drained", 0, remaining, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_top.md
Name: soc_top

Overview:
- Top-level of the demo SoC image: after reset, emits a fixed boot message byte-by-byte on a UART write strobe interface, then lights the LED as a "done/pass" indicator.
- The UART sink is external (the testbench or board UART TX) and always accepts; there is no backpressure.
- Self-contained: no inputs besides clock and reset.

Parameters:
- START_DELAY, 4: cycles to wait after reset release before the first byte (range 0..255).
- GAP_CYCLES, 3: idle cycles between consecutive byte strobes (0 means back-to-back).
- REPEAT, 0: 0 sends the message once, then goes to DONE; 1 loops the message forever.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- uart_wr_valid  output  1  one-cycle strobe; the byte on uart_wr_data is written when high.
- uart_wr_data  output  8  byte to write; 8'h00 whenever uart_wr_valid is low.
- LED  output  1  message-complete indicator.

Behaviour:
- Message ROM holds 14 bytes, ASCII "Hello, world!\n": 48 65 6C 6C 6F 2C 20 77 6F 72 6C 64 21 0A. Index idx is 4 bits, 0..13.
- All outputs are registered, driven directly from flops.
- Reset (RST_N low) takes effect immediately, independent of CLK:
  - uart_wr_valid=0, uart_wr_data=0, LED=0.
  - state=WAIT, idx=0, counters=0.
- States: WAIT, SEND, GAP, DONE.
- WAIT: counter increments each edge. After START_DELAY edges it enters SEND; with START_DELAY=0 it enters SEND on the first edge.
- SEND: lasts exactly one cycle with uart_wr_valid=1 and uart_wr_data=ROM[idx]. Then:
  - if idx<13: idx+1, go to GAP (or straight to SEND if GAP_CYCLES=0).
  - if idx==13 and REPEAT=0: go to DONE.
  - if idx==13 and REPEAT=1: idx=0, toggle LED, go to GAP/SEND as above.
- GAP: GAP_CYCLES cycles with valid=0 and data=0, then SEND.
- DONE: valid=0, data=0, LED=1. Holds until reset; terminal.
- Timing, numbering rising edges after RST_N rises as 1, 2, …:
  - Byte k (0..13) is presented in the cycle after edge START_DELAY+1+k*(GAP_CYCLES+1).
  - LED rises in the cycle after the edge that ends the last strobe.
- Exactly one valid cycle per byte; valid is never high two consecutive cycles unless GAP_CYCLES=0.
- Reset mid-message: outputs clear asynchronously. After release the sequence restarts from WAIT and byte 0; no partial resume.
- Reset asserted in DONE clears LED.

Test Plan:
- Defaults, RST_N low for 5 edges then high:
  - first strobe 0x48 after edge 5, then strobes after edges 9, 13, …, last 0x0A after edge 57.
  - exactly 14 strobes; LED 0 until after edge 58, then 1 permanently.
- Capture all bytes where uart_wr_valid=1 -> byte stream equals "Hello, world!\n". uart_wr_data is 0x00 on every non-valid cycle.
- During reset -> uart_wr_valid=0, uart_wr_data=0, LED=0 immediately, even with CLK stopped.
- Assert RST_N low asynchronously after 3 strobes, then release:
  - outputs cleared at once.
  - stream restarts with 0x48 after START_DELAY+1 edges.
  - total captured after release is the full 14-byte message.
- GAP_CYCLES=0, START_DELAY=0 -> 14 consecutive valid cycles starting after edge 1, LED high after edge 15.
- REPEAT=1, defaults otherwise -> message repeats every 56 cycles; LED toggles after each 0x0A strobe (1 after first pass, 0 after second); never enters DONE.
